// File: rtl/stdio_controller_if.sv
// UART-side bundle of the stdio controller: RX byte strobe in,
// TX byte out over a valid/ready handshake.
interface stdio_controller_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    input  rx_valid,
    input  rx_data,
    input  tx_ready,
    output tx_valid,
    output tx_data
  );

  modport slave (
    output rx_valid,
    output rx_data,
    output tx_ready,
    input  tx_valid,
    input  tx_data
  );
endinterface

// File: rtl/stdio_controller.sv
// Stalls the core around stdin/stdout instructions, buffers UART RX
// bytes in a small FIFO and feeds UART TX over valid/ready.
module stdio_controller #(
  parameter int RX_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      instr_valid,
  input  logic                      stdin_read_enable,
  input  logic                      stdout_write_enable,
  input  logic [7:0]                stdout_data,
  output logic                      stall,
  output logic                      done,
  output logic [31:0]               stdin_data,
  stdio_controller_if.master        uart,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      rx_overflow
);

  localparam int AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RX_WAIT,
    TX_WAIT,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  mem [RX_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        req_in;
  logic        req_out;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        tx_load;
  logic        tx_clr;

  assign req_in  = instr_valid & stdin_read_enable;
  assign req_out = instr_valid & stdout_write_enable
                 & ~stdin_read_enable;

  assign rx_level = wr_ptr - rd_ptr;
  assign empty    = (rx_level == '0);
  // occupancy never exceeds RX_DEPTH, so the MSB alone flags full
  assign full     = rx_level[AW];
  assign push     = uart.rx_valid & (~full | pop);

  assign stall = (req_in | req_out) & (state_q != DONE);
  assign done  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_load = 1'b0;
    tx_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_in) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RX_WAIT;
          end
        end else if (req_out) begin
          tx_load = 1'b1;
          state_d = TX_WAIT;
        end
      end
      RX_WAIT: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = DONE;
        end
      end
      TX_WAIT: begin
        if (uart.tx_ready) begin
          tx_clr  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RX_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= uart.rx_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (uart.rx_valid & ~push) begin
        rx_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stdin_data    <= '0;
      uart.tx_valid <= 1'b0;
      uart.tx_data  <= '0;
    end else begin
      if (pop) begin
        stdin_data <= {24'h0, mem[rd_ptr[AW-1:0]]};
      end
      if (tx_load) begin
        uart.tx_valid <= 1'b1;
        uart.tx_data  <= stdout_data;
      end else if (tx_clr) begin
        uart.tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stdio_controller.sv
// Scoreboard bench for stdio_controller: directed scenarios, then
// random stdin/stdout traffic against a queue-based reference model.
module tb_stdio_controller;
  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     instr_valid = 1'b0;
  logic                     rd_en = 1'b0;
  logic                     wr_en = 1'b0;
  logic [7:0]               wr_data = '0;
  logic                     stall;
  logic                     done;
  logic [31:0]              stdin_data;
  logic [$clog2(DEPTH):0]   rx_level;
  logic                     rx_overflow;

  stdio_controller_if u_if ();

  stdio_controller #(.RX_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .instr_valid         (instr_valid),
    .stdin_read_enable   (rd_en),
    .stdout_write_enable (wr_en),
    .stdout_data         (wr_data),
    .stall               (stall),
    .done                (done),
    .stdin_data          (stdin_data),
    .uart                (u_if.master),
    .rx_level            (rx_level),
    .rx_overflow         (rx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  k;
    logic [31:0] e;
  } probe_t;

  typedef struct packed {
    logic       rd;
    logic [7:0] d;
  } op_t;

  probe_t     pq[$];
  op_t        opq[$];
  logic [7:0] txq[$];

  // reference model state
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  int         ph = 0;
  logic [7:0] m_stdin = '0;
  logic [7:0] m_txd = '0;

  int checks = 0;
  int errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    probe_t p;
    op_t    o;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      case (p.k)
        3'd0: chk("stall", 32'(stall), p.e);
        3'd1: chk("done", 32'(done), p.e);
        3'd2: chk("rx_level", 32'(rx_level), p.e);
        3'd3: chk("rx_overflow", 32'(rx_overflow), p.e);
        3'd4: chk("tx_valid", 32'(u_if.tx_valid), p.e);
        3'd5: chk("tx_data", 32'(u_if.tx_data), p.e);
        default: chk("stdin_data", stdin_data, p.e);
      endcase
    end
    if (!rstn) begin
      opq.delete();
      txq.delete();
    end else begin
      if (done) begin
        chk("done_pair", 32'(prev_done), 32'd0);
        if (opq.size() == 0) begin
          chk("done_expected", 32'd1, 32'd0);
        end else begin
          o = opq.pop_front();
          if (o.rd) chk("read_byte", stdin_data, {24'h0, o.d});
        end
      end
      if (u_if.tx_valid && u_if.tx_ready) begin
        if (txq.size() == 0) begin
          chk("tx_expected", 32'd1, 32'd0);
        end else begin
          chk("tx_byte", 32'(u_if.tx_data), 32'(txq.pop_front()));
        end
      end
    end
    prev_done = done;
  end

  task automatic probe(input int k, input logic [31:0] e);
    probe_t p;
    p.k = 3'(k);
    p.e = e;
    pq.push_back(p);
  endtask

  function automatic logic rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // one cycle: drive inputs, record expectations, advance the model
  task automatic step(input logic iv, input logic rd, input logic wr,
                      input logic [7:0] wd, input logic rxv,
                      input logic [7:0] rxd, input logic txr);
    logic ri, ro;
    int   ph0;
    op_t  o;
    @(posedge clk);
    #1;
    instr_valid   = iv;
    rd_en         = rd;
    wr_en         = wr;
    wr_data       = wd;
    u_if.rx_valid = rxv;
    u_if.rx_data  = rxd;
    u_if.tx_ready = txr;
    ri  = iv & rd;
    ro  = iv & wr & ~rd;
    ph0 = ph;
    probe(0, 32'((ri | ro) && ph0 != 3));
    probe(1, 32'(ph0 == 3));
    probe(2, 32'(mq.size()));
    probe(3, 32'(m_ovf));
    probe(4, 32'(ph0 == 2));
    probe(5, 32'(m_txd));
    probe(6, {24'h0, m_stdin});
    if (ph0 == 3) begin
      ph = 0;
    end else if (ph0 == 2) begin
      if (txr) ph = 3;
    end else if (ph0 == 1 || ri) begin
      if (mq.size() > 0) begin
        o.rd    = 1'b1;
        o.d     = mq.pop_front();
        m_stdin = o.d;
        opq.push_back(o);
        ph = 3;
      end else begin
        ph = 1;
      end
    end else if (ro) begin
      o.rd  = 1'b0;
      o.d   = wd;
      m_txd = wd;
      opq.push_back(o);
      txq.push_back(wd);
      ph = 2;
    end
    if (rxv) begin
      if (mq.size() < DEPTH) mq.push_back(rxd);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic idle(input logic rxv, input logic [7:0] rxd);
    step(1'b0, 1'b0, 1'b0, 8'h00, rxv, rxd, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn          = 1'b0;
    instr_valid   = 1'b0;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    u_if.rx_valid = 1'b0;
    u_if.tx_ready = 1'b0;
    mq.delete();
    m_ovf   = 1'b0;
    ph      = 0;
    m_stdin = '0;
    m_txd   = '0;
    probe(0, 32'd0);
    probe(1, 32'd0);
    probe(2, 32'd0);
    probe(3, 32'd0);
    probe(4, 32'd0);
    probe(5, 32'd0);
    probe(6, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // issue one I/O instruction and hold it until it retires
  task automatic op(input logic rd, input logic [7:0] wd,
                    input int rxp, input int txp, input logic drop);
    int   n = 0;
    logic wr, iv, rxv;
    wr = rd ? logic'($urandom_range(0, 1)) : 1'b1;
    step(1'b1, rd, wr, wd, rnd(rxp), 8'($urandom), rnd(txp));
    while (ph != 0) begin
      n++;
      iv  = (drop && ph != 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
      rxv = rnd(rxp) || (ph == 1 && n > 20);
      step(iv, rd, wr, wd, rxv, 8'($urandom), rnd(txp) || n > 40);
    end
  endtask

  initial begin
    u_if.rx_valid = 1'b0;
    u_if.rx_data  = '0;
    u_if.tx_ready = 1'b0;
    do_reset();

    // buffered byte, issue two cycles after the strobe
    idle(1'b1, 8'h41);
    idle(1'b0, 8'h00);
    op(1'b1, 8'h00, 0, 0, 1'b0);

    // empty FIFO: wait, then byte arrives
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h7A, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // stdout with back-pressure
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);

    // overflow on a full FIFO
    for (int i = 1; i <= 5; i++) idle(1'b1, 8'(i));
    repeat (4) op(1'b1, 8'h00, 0, 0, 1'b0);
    idle(1'b0, 8'h00);

    // pop and push together on a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) idle(1'b1, 8'hA0 + 8'(i));
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (4) op(1'b1, 8'h00, 0, 0, 1'b0);
    idle(1'b0, 8'h00);

    // reset while a TX byte is pending
    idle(1'b1, 8'h33);
    step(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
    do_reset();
    idle(1'b0, 8'h00);
    op(1'b0, 8'h3C, 0, 50, 1'b0);

    // random traffic
    repeat (300) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op(1'b1, 8'h00, 30, 40, 1'b1);
        4, 5, 6, 7: op(1'b0, 8'($urandom), 30, 40, 1'b1);
        default:    idle(rnd(50), 8'($urandom));
      endcase
    end

    repeat (3) idle(1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stdio_controller.md
# stdio_controller

Sequencing controller for the core's custom stdin/stdout instructions. Takes the decoded `stdin_read_enable` / `stdout_write_enable` controls for the instruction in execute, stalls the core while the I/O transfer is pending, and hands back the read byte for register write-back. Buffers incoming UART bytes in a small FIFO and drives the UART transmitter over a valid/ready handshake. Sits between the decoder/execute stage and the UART RX/TX blocks.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- `RX_DEPTH`, default 4: RX FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `instr_valid`  in  1  execute-stage instruction is valid; qualifies both enables.
- `stdin_read_enable`  in  1  decoded stdin instruction.
- `stdout_write_enable`  in  1  decoded stdout instruction.
- `stdout_data`  in  8  byte to send (rs1[7:0]); sampled at issue.
- `stall`  out  1  core holds PC, pipeline and register file.
- `done`  out  1  one-cycle pulse: I/O instruction completes this cycle; core retires it.
- `stdin_data`  out  32  read byte zero-extended; valid while `done`=1 for a stdin op.
- `rx_valid`  in  1  UART RX byte strobe (one cycle per byte).
- `rx_data`  in  8  UART RX byte.
- `tx_valid`  out  1  byte available to UART TX.
- `tx_data`  out  8  byte to UART TX.
- `tx_ready`  in  1  UART TX accepts when `tx_valid` & `tx_ready`.
- `rx_level`  out  $clog2(RX_DEPTH)+1  current FIFO occupancy.
- `rx_overflow`  out  1  sticky: a byte was dropped on a full FIFO.

## Operation
- Request: `req_in` = `instr_valid` & `stdin_read_enable`; `req_out` = `instr_valid` & `stdout_write_enable` & !`stdin_read_enable` (stdin wins if both set).
- `stall` = (`req_in` | `req_out`) & (state != DONE). Combinational; 0 when no I/O request.
- RX FIFO: push on `rx_valid` unless full (then drop byte, set `rx_overflow`). Pop only by FSM. Push and pop in the same cycle on a full FIFO: both take effect, no overflow, level unchanged. A byte pushed in cycle N is poppable no earlier than cycle N+1.
- FSM states IDLE, RX_WAIT, TX_WAIT, DONE:
  - IDLE: `req_in` & level>0 → pop head into `stdin_data`, go DONE. `req_in` & level=0 → RX_WAIT. `req_out` → latch `stdout_data` into `tx_data`, set `tx_valid`, go TX_WAIT. Else stay.
  - RX_WAIT: level>0 → pop into `stdin_data`, go DONE; else stay.
  - TX_WAIT: `tx_valid`=1, `tx_data` stable. On `tx_ready` → clear `tx_valid`, go DONE.
  - DONE: `done`=1, `stall`=0 for one cycle; go IDLE unconditionally. The next I/O instruction is issued no earlier than the following cycle.
- `stdin_data` holds the last value read until the next stdin completion.
- `instr_valid` dropping while in RX_WAIT/TX_WAIT does not abort; the operation completes (the core never flushes a stalled instruction).

## Timing
- Reset (async assert, sync deassert externally): state IDLE, FIFO empty, `rx_level`=0, `rx_overflow`=0, `tx_valid`=0, `tx_data`=0, `stdin_data`=0, `done`=0. Reset mid-transfer abandons it; a pending TX byte is discarded.
- stdin, FIFO non-empty: issue cycle N stalled; `done` in N+1. Latency 1.
- stdin, FIFO empty: byte strobed in cycle M → pop in M+1, `done` in M+2.
- stdout: issue N; `tx_valid` from N+1; `tx_ready` in cycle K≥N+1 → `done` in K+1, `tx_valid`=0 in K+1.
- `done` is never asserted in two consecutive cycles.

## Test plan
- Reset, then push 0x41 via `rx_valid`; issue stdin 2 cycles later → `stall`=1 one cycle, then `done`=1, `stdin_data`=0x00000041, `rx_level` 1→0.
- Issue stdin with empty FIFO, hold 5 cycles, strobe 0x7A → `stall` held through strobe+1, `done` at strobe+2, `stdin_data`=0x0000007A.
- Issue stdout with `stdout_data`=0x55, `tx_ready` low 3 cycles then high → `tx_valid`=1, `tx_data`=0x55 stable throughout, `done` the cycle after accept, `tx_valid`=0.
- Push 5 bytes 0x01..0x05 with RX_DEPTH=4 → `rx_level`=4, `rx_overflow`=1; four stdin reads return 0x01..0x04 in order.
- FIFO full, stdin pop coinciding with `rx_valid` 0x99 → no overflow, `rx_level` stays 4, 0x99 read last.
- Assert `rstn` low while in TX_WAIT → `tx_valid`=0, `stall`=0 (with enables low), `rx_level`=0 immediately; a new stdout after release completes normally.
